// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// --------------------
// Stall/flush controller for the in-order pipeline. It sits beside the ID
// stage and decides, every cycle, whether the ID instruction issues into EX,
// stalls, or is killed. A scoreboard tracks registers with outstanding
// long-latency writes (loads, mul/div). FENCE waits until the scoreboard is
// empty and the MDU is idle. An EX-resolved redirect flushes the front end
// for the redirect cycle plus FLUSH_CYCLES further cycles.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   id_valid                     ID holds a valid instruction
//   id_rs1/id_rs2/id_rd          register indices of the ID instruction
//   id_use_rs1/id_use_rs2        instruction reads rs1 / rs2
//   id_reg_write                 instruction writes rd
//   id_long                      result arrives via late writeback
//   id_mdu                       instruction needs the mul/div unit
//   id_fence                     instruction is FENCE
//   mdu_ready                    mul/div unit can accept an operation
//   ex_redirect                  EX resolved a taken branch/jump
//   wb_valid/wb_rd               long-latency writeback and its destination
//   stall                        hold PC, IF/ID and ID state
//   flush_id / flush_ex          bubble into IF/ID / ID/EX
//   issue                        ID instruction advances into EX
//   sb_busy                      any scoreboard bit set
//   state_o                      FSM state (RUN=0, STALL=1, DRAIN=2, FLUSH=3)
module pipeline_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] id_rd,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic       id_reg_write,
  input  logic       id_long,
  input  logic       id_mdu,
  input  logic       id_fence,
  input  logic       mdu_ready,
  input  logic       ex_redirect,
  input  logic       wb_valid,
  input  logic [4:0] wb_rd,
  output logic       stall,
  output logic       flush_id,
  output logic       flush_ex,
  output logic       issue,
  output logic       sb_busy,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    DRAIN = 2'd2,
    FLUSH = 2'd3
  } state_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  state_t      state_reg, state_next;
  logic [2:0]  cnt_reg, cnt_next;
  // Bit 0 exists only to keep indexing simple; it is held at zero.
  logic [31:0] sb_reg, sb_next;

  logic        rs1_hit, rs2_hit, rd_hit, mdu_hit;
  logic        hazard, fence_block;
  logic [31:0] set_mask, clr_mask;

  // Hazard detection against the scoreboard. The rd term is the WAW stall
  // that also guarantees a set and clear never collide on one bit.
  always_comb begin
    rs1_hit     = id_use_rs1   && (id_rs1 != 5'd0) && sb_reg[id_rs1];
    rs2_hit     = id_use_rs2   && (id_rs2 != 5'd0) && sb_reg[id_rs2];
    rd_hit      = id_reg_write && (id_rd  != 5'd0) && sb_reg[id_rd];
    mdu_hit     = id_mdu && !mdu_ready;
    hazard      = id_valid && (rs1_hit || rs2_hit || rd_hit || mdu_hit);
    fence_block = id_valid && id_fence && ((sb_reg[31:1] != 31'd0) || !mdu_ready);
    issue       = id_valid && !hazard && !fence_block && !ex_redirect &&
                  (state_reg != FLUSH);
  end

  // Scoreboard update: set has priority over clear.
  always_comb begin
    set_mask = 32'd0;
    clr_mask = 32'd0;
    if (issue && id_reg_write && id_long && (id_rd != 5'd0)) begin
      set_mask = 32'd1 << id_rd;
    end
    if (wb_valid && (wb_rd != 5'd0)) begin
      clr_mask = 32'd1 << wb_rd;
    end
    sb_next    = (sb_reg & ~clr_mask) | set_mask;
    sb_next[0] = 1'b0;
  end

  // Next-state and control outputs.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    stall      = 1'b0;
    flush_id   = 1'b0;
    flush_ex   = 1'b0;

    if (ex_redirect) begin
      // Redirect overrides everything; a stalled ID instruction is dropped.
      flush_id   = 1'b1;
      flush_ex   = 1'b1;
      cnt_next   = FLUSH_LOAD;
      state_next = (FLUSH_CYCLES == 0) ? RUN : FLUSH;
    end else if (state_reg == FLUSH) begin
      flush_id = 1'b1;
      flush_ex = 1'b1;
      cnt_next = (cnt_reg != 3'd0) ? cnt_reg - 3'd1 : 3'd0;
      // Leave once this cycle consumes the last count so that exactly
      // FLUSH_CYCLES cycles are spent here.
      if (cnt_reg <= 3'd1) begin
        state_next = RUN;
      end
    end else begin
      if (hazard || fence_block) begin
        stall    = 1'b1;
        flush_ex = 1'b1;
      end
      case (state_reg)
        RUN: begin
          if (fence_block)  state_next = DRAIN;
          else if (hazard)  state_next = STALL;
        end
        STALL: begin
          if (hazard)           state_next = STALL;
          else if (fence_block) state_next = DRAIN;
          else                  state_next = RUN;
        end
        DRAIN: begin
          if (fence_block)  state_next = DRAIN;
          else if (hazard)  state_next = STALL;
          else              state_next = RUN;
        end
        default: state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= RUN;
      cnt_reg   <= 3'd0;
      sb_reg    <= 32'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      sb_reg    <= sb_next;
    end
  end

  assign sb_busy = |sb_reg[31:1];
  assign state_o = state_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl (FLUSH_CYCLES=2).
module tb_pipeline_hazard_ctrl;

  logic       clk;
  logic       reset_n;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_use_rs1, id_use_rs2, id_reg_write, id_long, id_mdu, id_fence;
  logic       mdu_ready, ex_redirect, wb_valid;
  logic [4:0] wb_rd;
  logic       stall, flush_id, flush_ex, issue, sb_busy;
  logic [1:0] state_o;

  int tests_run = 0;
  int tests_failed = 0;

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_reg_write(id_reg_write), .id_long(id_long), .id_mdu(id_mdu),
    .id_fence(id_fence), .mdu_ready(mdu_ready), .ex_redirect(ex_redirect),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .stall(stall), .flush_id(flush_id), .flush_ex(flush_ex), .issue(issue),
    .sb_busy(sb_busy), .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs driven and outputs sampled 1 time unit after posedge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_use_rs1 = 0; id_use_rs2 = 0; id_reg_write = 0; id_long = 0;
    id_mdu = 0; id_fence = 0; mdu_ready = 1; ex_redirect = 0;
    wb_valid = 0; wb_rd = 0;
  endtask

  // Present an instruction in ID.
  task automatic instr(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                       input logic u2, input logic [4:0] rd, input logic wr,
                       input logic lng, input logic mdu, input logic fence);
    id_valid = 1; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    id_rd = rd; id_reg_write = wr; id_long = lng; id_mdu = mdu; id_fence = fence;
  endtask

  task automatic test_reset();
    idle();
    reset_n = 0;
    #2;
    tests_run++; if (state_o !== 2'd0) begin tests_failed++; $display("FAIL reset_state: got %0d want 0", state_o); end
    tests_run++; if ({stall, flush_id, flush_ex, issue, sb_busy} !== 5'b0) begin tests_failed++; $display("FAIL reset_outputs: got %b want 00000", {stall, flush_id, flush_ex, issue, sb_busy}); end
    @(negedge clk);
    reset_n = 1;
    cyc();
    $display("[TB] reset done");
  endtask

  task automatic test_load_use();
    instr(5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0, 0);  // lw x5, 0(x1)
    #1;
    tests_run++; if (issue !== 1'b1) begin tests_failed++; $display("FAIL lu_load_issue: got %b want 1", issue); end
    cyc();
    instr(5'd5, 1, 5'd1, 1, 5'd6, 1, 0, 0, 0);  // add x6, x5, x1
    #1;
    tests_run++; if ({stall, flush_ex, issue} !== 3'b110) begin tests_failed++; $display("FAIL lu_stall: got %b want 110", {stall, flush_ex, issue}); end
    tests_run++; if (sb_busy !== 1'b1) begin tests_failed++; $display("FAIL lu_sb_busy: got %b want 1", sb_busy); end
    cyc();
    tests_run++; if (state_o !== 2'd1 || stall !== 1'b1) begin tests_failed++; $display("FAIL lu_state_stall: got state %0d stall %b want 1/1", state_o, stall); end
    wb_valid = 1; wb_rd = 5'd5;
    #1;
    tests_run++; if (stall !== 1'b1 || issue !== 1'b0) begin tests_failed++; $display("FAIL lu_no_bypass: got stall %b issue %b want 1/0", stall, issue); end
    cyc();
    wb_valid = 0;
    #1;
    tests_run++; if ({stall, flush_ex, issue, sb_busy} !== 4'b0010) begin tests_failed++; $display("FAIL lu_release: got %b want 0010", {stall, flush_ex, issue, sb_busy}); end
    cyc();
    idle();
    #1;
    tests_run++; if (state_o !== 2'd0) begin tests_failed++; $display("FAIL lu_back_run: got %0d want 0", state_o); end
    $display("[TB] load-use done");
  endtask

  task automatic test_x0();
    instr(5'd2, 1, 5'd0, 0, 5'd0, 1, 1, 0, 0);  // lw x0
    #1;
    tests_run++; if (issue !== 1'b1) begin tests_failed++; $display("FAIL x0_load_issue: got %b want 1", issue); end
    cyc();
    instr(5'd0, 1, 5'd0, 1, 5'd8, 1, 0, 0, 0);  // add x8, x0, x0
    #1;
    tests_run++; if ({issue, stall, sb_busy} !== 3'b100) begin tests_failed++; $display("FAIL x0_consumer: got %b want 100", {issue, stall, sb_busy}); end
    cyc();
    idle();
    $display("[TB] x0 done");
  endtask

  task automatic test_waw_mdu();
    instr(5'd1, 1, 5'd2, 1, 5'd7, 1, 1, 1, 0);  // div x7
    #1;
    tests_run++; if (issue !== 1'b1) begin tests_failed++; $display("FAIL mdu_div_issue: got %b want 1", issue); end
    cyc();
    instr(5'd3, 1, 5'd4, 1, 5'd7, 1, 1, 1, 0);  // mul x7 (WAW)
    mdu_ready = 0;
    #1;
    tests_run++; if ({stall, issue} !== 2'b10) begin tests_failed++; $display("FAIL mdu_waw_stall: got %b want 10", {stall, issue}); end
    cyc();
    wb_valid = 1; wb_rd = 5'd7;
    #1;
    tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("FAIL mdu_wb_cycle: got %b want 1", stall); end
    cyc();
    wb_valid = 0;
    #1;
    tests_run++; if ({stall, sb_busy, state_o} !== 4'b1001) begin tests_failed++; $display("FAIL mdu_not_ready: got %b want 1001", {stall, sb_busy, state_o}); end
    cyc();
    mdu_ready = 1;
    #1;
    tests_run++; if ({stall, issue} !== 2'b01) begin tests_failed++; $display("FAIL mdu_issue: got %b want 01", {stall, issue}); end
    cyc();
    idle();
    #1;
    tests_run++; if (sb_busy !== 1'b1) begin tests_failed++; $display("FAIL mdu_sb_set: got %b want 1", sb_busy); end
    wb_valid = 1; wb_rd = 5'd7;
    cyc();
    wb_valid = 0;
    #1;
    tests_run++; if (sb_busy !== 1'b0) begin tests_failed++; $display("FAIL mdu_sb_clear: got %b want 0", sb_busy); end
    $display("[TB] waw/mdu done");
  endtask

  task automatic test_fence();
    instr(5'd1, 1, 5'd0, 0, 5'd3, 1, 1, 0, 0);  // lw x3
    cyc();
    instr(5'd1, 1, 5'd0, 0, 5'd4, 1, 1, 0, 0);  // lw x4 (back to back)
    #1;
    tests_run++; if (issue !== 1'b1) begin tests_failed++; $display("FAIL fence_b2b_issue: got %b want 1", issue); end
    cyc();
    instr(5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1);  // fence
    #1;
    tests_run++; if ({stall, flush_ex, flush_id, issue} !== 4'b1100) begin tests_failed++; $display("FAIL fence_block: got %b want 1100", {stall, flush_ex, flush_id, issue}); end
    cyc();
    tests_run++; if (state_o !== 2'd2) begin tests_failed++; $display("FAIL fence_drain_state: got %0d want 2", state_o); end
    wb_valid = 1; wb_rd = 5'd3;
    cyc();
    wb_rd = 5'd4;
    #1;
    tests_run++; if ({stall, sb_busy} !== 2'b11) begin tests_failed++; $display("FAIL fence_x3_cleared: got %b want 11", {stall, sb_busy}); end
    cyc();
    wb_valid = 0;
    #1;
    tests_run++; if ({issue, stall, sb_busy} !== 3'b100) begin tests_failed++; $display("FAIL fence_issue: got %b want 100", {issue, stall, sb_busy}); end
    cyc();
    idle();
    #1;
    tests_run++; if (state_o !== 2'd0) begin tests_failed++; $display("FAIL fence_back_run: got %0d want 0", state_o); end
    $display("[TB] fence done");
  endtask

  task automatic test_redirect();
    instr(5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0, 0);  // lw x5
    cyc();
    instr(5'd5, 1, 5'd0, 0, 5'd9, 1, 0, 0, 0);  // consumer of x5
    cyc();
    tests_run++; if (state_o !== 2'd1) begin tests_failed++; $display("FAIL rd_stall_state: got %0d want 1", state_o); end
    ex_redirect = 1;
    #1;
    tests_run++; if ({stall, flush_id, flush_ex, issue} !== 4'b0110) begin tests_failed++; $display("FAIL rd_redirect_cycle: got %b want 0110", {stall, flush_id, flush_ex, issue}); end
    cyc();
    ex_redirect = 0;  // the stalled consumer is still presented but must not issue
    #1;
    tests_run++; if ({state_o, stall, flush_id, flush_ex, issue} !== 6'b110110) begin tests_failed++; $display("FAIL rd_flush1: got %b want 110110", {state_o, stall, flush_id, flush_ex, issue}); end
    cyc();
    tests_run++; if ({state_o, stall, flush_id, flush_ex, issue} !== 6'b110110) begin tests_failed++; $display("FAIL rd_flush2: got %b want 110110", {state_o, stall, flush_id, flush_ex, issue}); end
    cyc();
    idle();
    #1;
    tests_run++; if ({state_o, flush_id, flush_ex, sb_busy} !== 5'b00001) begin tests_failed++; $display("FAIL rd_back_run: got %b want 00001", {state_o, flush_id, flush_ex, sb_busy}); end
    wb_valid = 1; wb_rd = 5'd5;
    cyc();
    wb_valid = 0;
    #1;
    tests_run++; if (sb_busy !== 1'b0) begin tests_failed++; $display("FAIL rd_sb_clear: got %b want 0", sb_busy); end
    $display("[TB] redirect done");
  endtask

  task automatic test_reset_mid();
    instr(5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0, 0);  // lw x5
    cyc();
    instr(5'd1, 1, 5'd0, 0, 5'd6, 1, 1, 0, 0);  // lw x6 -> sb = 0x60
    cyc();
    idle();
    ex_redirect = 1;
    cyc();
    ex_redirect = 0;
    #1;
    tests_run++; if ({state_o, sb_busy} !== 3'b111) begin tests_failed++; $display("FAIL rm_pre_state: got %b want 111", {state_o, sb_busy}); end
    #1;
    reset_n = 0;
    #1;
    tests_run++; if ({state_o, sb_busy, stall, flush_id} !== 5'b00000) begin tests_failed++; $display("FAIL rm_async: got %b want 00000", {state_o, sb_busy, stall, flush_id}); end
    @(negedge clk);
    reset_n = 1;
    cyc();
    tests_run++; if ({state_o, sb_busy} !== 3'b000) begin tests_failed++; $display("FAIL rm_after: got %b want 000", {state_o, sb_busy}); end
    $display("[TB] reset mid-flush done");
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_x0();
    test_waw_mdu();
    test_fence();
    test_redirect();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
